// File: rtl/serial_display_driver.sv
// serial_display_driver
// Shifts a full display frame into an external shift-register chain
// (1..4 parallel data lines), then pulses the storage-register latch.
// The frame is taken over a valid/ready handshake into a shadow register, so
// the source may change i_frame/i_blank as soon as the frame is accepted.
//
// Ports:
//   i_clk           system clock
//   i_reset         synchronous, active-high reset (aborts a transfer, no latch)
//   i_en            enable; gates frame acceptance only
//   i_frame         frame data, digit 0 in the LSBs
//   i_frame_valid   frame offered
//   i_blank         sampled at acceptance; captures an all-zero frame instead
//   o_frame_ready   driver idle and enabled (combinational)
//   o_busy          transfer in progress
//   o_serial_data   one serial data line per chain
//   o_serial_latch  storage-register latch pulse
//   o_serial_clk    shift clock
module serial_display_driver #(
    parameter int unsigned SYS_CLK_HZ   = 5_000_000,
    parameter int unsigned SHIFT_CLK_HZ = 1_000_000,
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SEG_BITS     = 8,
    parameter int unsigned NUM_CHAINS   = 1,
    parameter int unsigned MSB_FIRST    = 1,
    parameter int unsigned INVERT_OUT   = 0
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_en,
    input  logic [NUM_DIGITS*SEG_BITS-1:0]   i_frame,
    input  logic                             i_frame_valid,
    input  logic                             i_blank,
    output logic                             o_frame_ready,
    output logic                             o_busy,
    output logic [NUM_CHAINS-1:0]            o_serial_data,
    output logic                             o_serial_latch,
    output logic                             o_serial_clk
);

    localparam int unsigned FRAME_W  = NUM_DIGITS * SEG_BITS;
    localparam int unsigned BPC      = FRAME_W / NUM_CHAINS;
    localparam int unsigned HALF_RAW = SYS_CLK_HZ / (2 * SHIFT_CLK_HZ);
    localparam int unsigned HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int unsigned HALF_W   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned BPC_W    = (BPC > 1) ? $clog2(BPC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_HIGH  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t                 r_state;
    logic [HALF_W-1:0]      r_half_cnt;
    logic [BPC_W-1:0]       r_bit_cnt;
    logic [FRAME_W-1:0]     r_shadow;
    logic [NUM_CHAINS-1:0]  r_data;
    logic                   r_latch;
    logic                   r_sclk;
    logic                   r_busy;

    state_t                 w_state_nxt;
    logic [HALF_W-1:0]      w_half_nxt;
    logic [BPC_W-1:0]       w_bit_nxt;
    logic [FRAME_W-1:0]     w_shadow_nxt;
    logic [NUM_CHAINS-1:0]  w_data_nxt;
    logic [BPC_W-1:0]       w_bit_idx;
    logic [BPC-1:0]         w_chain;
    logic                   w_accept;
    logic                   w_half_done;
    logic                   w_last_bit;

    assign o_frame_ready = (r_state == S_IDLE) && i_en;
    assign w_accept      = o_frame_ready && i_frame_valid;
    assign w_half_done   = (r_half_cnt == HALF_W'(HALF - 1));
    assign w_last_bit    = (r_bit_cnt == BPC_W'(BPC - 1));

    // Next-state, phase counter, bit counter and shadow capture
    always_comb begin
        w_state_nxt  = r_state;
        w_half_nxt   = r_half_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_shadow_nxt = r_shadow;
        unique case (r_state)
            S_IDLE: begin
                w_half_nxt = '0;
                if (w_accept) begin
                    w_state_nxt  = S_SETUP;
                    w_bit_nxt    = '0;
                    w_shadow_nxt = i_blank ? '0 : i_frame;
                end
            end
            S_SETUP: begin
                w_half_nxt = w_half_done ? '0 : r_half_cnt + HALF_W'(1);
                if (w_half_done) begin
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                w_half_nxt = w_half_done ? '0 : r_half_cnt + HALF_W'(1);
                if (w_half_done) begin
                    if (w_last_bit) begin
                        w_state_nxt = S_LATCH;
                    end else begin
                        w_state_nxt = S_SETUP;
                        w_bit_nxt   = r_bit_cnt + BPC_W'(1);
                    end
                end
            end
            S_LATCH: begin
                w_half_nxt = w_half_done ? '0 : r_half_cnt + HALF_W'(1);
                if (w_half_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Data for the upcoming state; the bit counter only moves on SETUP entry,
    // so data is held through HIGH and LATCH without extra gating.
    always_comb begin
        w_data_nxt = '0;
        w_chain    = '0;
        w_bit_idx  = (MSB_FIRST != 0) ? (BPC_W'(BPC - 1) - w_bit_nxt) : w_bit_nxt;
        if (w_state_nxt != S_IDLE) begin
            for (int k = 0; k < int'(NUM_CHAINS); k++) begin
                w_chain       = w_shadow_nxt[k*BPC +: BPC];
                w_data_nxt[k] = w_chain[w_bit_idx] ^ (INVERT_OUT != 0);
            end
        end
    end

    // State and registered pin drivers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shadow   <= '0;
            r_data     <= '0;
            r_latch    <= 1'b0;
            r_sclk     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_half_cnt <= w_half_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shadow   <= w_shadow_nxt;
            r_data     <= w_data_nxt;
            r_latch    <= (w_state_nxt == S_LATCH);
            r_sclk     <= (w_state_nxt == S_HIGH);
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    assign o_busy         = r_busy;
    assign o_serial_data  = r_data;
    assign o_serial_latch = r_latch;
    assign o_serial_clk   = r_sclk;

endmodule

// File: tb/tb_serial_display_driver.sv
// Directed bench for serial_display_driver: a base instance (1 chain, MSB
// first), an inverted-output instance and a 2-chain LSB-first instance.
module tb_serial_display_driver;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic        blank;
    logic [15:0] frame;
    logic        v0, v1, v2;

    logic        rdy0, busy0, d0, lat0, sc0;
    logic        rdy1, busy1, d1, lat1, sc1;
    logic        rdy2, busy2, lat2, sc2;
    logic [1:0]  d2;

    int n_vec = 0;
    int n_err = 0;

    int          cap_busy, cap_edges, cap_latch_cyc, cap_latch_pulses;
    int          cap_first, cap_last, cap_glitch;
    logic [15:0] cap_c0, cap_c1;
    bit          cap_to;

    serial_display_driver #(
        .SYS_CLK_HZ(8_000_000), .SHIFT_CLK_HZ(1_000_000), .NUM_DIGITS(2),
        .SEG_BITS(8), .NUM_CHAINS(1), .MSB_FIRST(1), .INVERT_OUT(0)
    ) u_dut_a (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_frame(frame),
        .i_frame_valid(v0), .i_blank(blank), .o_frame_ready(rdy0),
        .o_busy(busy0), .o_serial_data(d0), .o_serial_latch(lat0),
        .o_serial_clk(sc0)
    );

    serial_display_driver #(
        .SYS_CLK_HZ(8_000_000), .SHIFT_CLK_HZ(1_000_000), .NUM_DIGITS(2),
        .SEG_BITS(8), .NUM_CHAINS(1), .MSB_FIRST(1), .INVERT_OUT(1)
    ) u_dut_inv (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_frame(frame),
        .i_frame_valid(v1), .i_blank(blank), .o_frame_ready(rdy1),
        .o_busy(busy1), .o_serial_data(d1), .o_serial_latch(lat1),
        .o_serial_clk(sc1)
    );

    serial_display_driver #(
        .SYS_CLK_HZ(8_000_000), .SHIFT_CLK_HZ(1_000_000), .NUM_DIGITS(2),
        .SEG_BITS(8), .NUM_CHAINS(2), .MSB_FIRST(0), .INVERT_OUT(0)
    ) u_dut_2ch (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_frame(frame),
        .i_frame_valid(v2), .i_blank(blank), .o_frame_ready(rdy2),
        .o_busy(busy2), .o_serial_data(d2), .o_serial_latch(lat2),
        .o_serial_clk(sc2)
    );

    // Offer a frame to one instance and return just after the accepting edge
    task automatic offer(input int which, input logic [15:0] f, input logic b);
        logic r;
        bit   ok;
        @(posedge clk); #1;
        frame = f;
        blank = b;
        case (which)
            0: v0 = 1'b1;
            1: v1 = 1'b1;
            default: v2 = 1'b1;
        endcase
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            case (which)
                0: r = rdy0;
                1: r = rdy1;
                default: r = rdy2;
            endcase
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL offer_timeout: inst %0d ready never seen, required 1", which);
        end
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    endtask

    // Record one transfer from the cycle after acceptance until busy falls
    task automatic capture(input int which, input int drop_at);
        logic       sc, sl, sb, pc, pl;
        logic [1:0] sd, pd;
        bit         seen;
        cap_busy = 0; cap_edges = 0; cap_latch_cyc = 0; cap_latch_pulses = 0;
        cap_first = 0; cap_last = 0; cap_glitch = 0;
        cap_c0 = '0; cap_c1 = '0; cap_to = 1'b1;
        pc = 1'b0; pl = 1'b0; pd = '0; seen = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (cyc == drop_at) en = 1'b0;
            case (which)
                0: begin sc = sc0; sl = lat0; sb = busy0; sd = {1'b0, d0}; end
                1: begin sc = sc1; sl = lat1; sb = busy1; sd = {1'b0, d1}; end
                default: begin sc = sc2; sl = lat2; sb = busy2; sd = d2; end
            endcase
            if (sb) begin
                cap_busy++;
                seen = 1'b1;
            end else if (seen) begin
                cap_to = 1'b0;
                break;
            end
            if (sc && !pc) begin
                cap_c0 = {cap_c0[14:0], sd[0]};
                cap_c1 = {cap_c1[14:0], sd[1]};
                if (cap_edges == 0) cap_first = cyc;
                cap_last = cyc;
                cap_edges++;
            end
            if (sl) cap_latch_cyc++;
            if (sl && !pl) cap_latch_pulses++;
            if ((sd != pd) && (sc || sl)) cap_glitch++;
            pc = sc; pl = sl; pd = sd;
        end
        if (cap_to) begin
            n_vec++; n_err++;
            $display("FAIL capture_timeout: inst %0d busy never returned low", which);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        blank = 1'b0; frame = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy0, sc0, lat0, d0} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 0000", {busy0, sc0, lat0, d0});
        end
        n_vec++;
        if (rdy0 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b required 1", rdy0);
        end
        rst = 1'b0;

        // Reset in the middle of a frame
        offer(0, 16'hA5C3, 1'b0);
        repeat (20) @(negedge clk);
        n_vec++;
        if (busy0 !== 1'b1) begin
            n_err++;
            $display("FAIL midframe_busy: got %b required 1", busy0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if ({busy0, sc0, lat0, d0} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_abort_%0d: got %b required 0000", i, {busy0, sc0, lat0, d0});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (rdy0 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_after: got %b required 1", rdy0);
        end
        begin
            int lat_seen;
            lat_seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (lat0 || busy0) lat_seen++;
            end
            n_vec++;
            if (lat_seen !== 0) begin
                n_err++;
                $display("FAIL reset_no_latch: got %0d active cycles required 0", lat_seen);
            end
        end
    endtask

    task automatic test_single_frame();
        offer(0, 16'hA5C3, 1'b0);
        capture(0, -1);
        n_vec++;
        if (cap_c0 !== 16'hA5C3) begin
            n_err++;
            $display("FAIL single_bits: got %h required a5c3", cap_c0);
        end
        n_vec++;
        if (cap_edges !== 16) begin
            n_err++;
            $display("FAIL single_edges: got %0d required 16", cap_edges);
        end
        n_vec++;
        if ((cap_last - cap_first) !== 120) begin
            n_err++;
            $display("FAIL single_period: got span %0d required 120", cap_last - cap_first);
        end
        n_vec++;
        if (cap_latch_pulses !== 1 || cap_latch_cyc !== 4) begin
            n_err++;
            $display("FAIL single_latch: got %0d pulses %0d cycles required 1 and 4",
                     cap_latch_pulses, cap_latch_cyc);
        end
        n_vec++;
        if (cap_busy !== 132) begin
            n_err++;
            $display("FAIL single_busy: got %0d required 132", cap_busy);
        end
        n_vec++;
        if (cap_glitch !== 0) begin
            n_err++;
            $display("FAIL single_data_hold: got %0d changes while clk/latch high required 0", cap_glitch);
        end
    endtask

    task automatic test_back_to_back();
        int lowcnt;
        bit ok;
        @(posedge clk); #1;
        frame = 16'hA5C3; blank = 1'b0; v0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy0) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        frame = 16'h00FF;
        lowcnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rdy0) begin ok = 1'b1; break; end
            lowcnt++;
        end
        n_vec++;
        if (!ok || lowcnt !== 132) begin
            n_err++;
            $display("FAIL b2b_ready_low: got %0d cycles required 132", lowcnt);
        end
        n_vec++;
        if (busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle_gap: got busy %b required 0", busy0);
        end
        @(posedge clk); #1;
        v0 = 1'b0;
        capture(0, -1);
        n_vec++;
        if (cap_c0 !== 16'h00FF) begin
            n_err++;
            $display("FAIL b2b_second_bits: got %h required 00ff", cap_c0);
        end
        n_vec++;
        if (cap_busy !== 132 || cap_edges !== 16) begin
            n_err++;
            $display("FAIL b2b_second_len: got busy %0d edges %0d required 132 and 16",
                     cap_busy, cap_edges);
        end
    endtask

    task automatic test_blank();
        offer(0, 16'hFFFF, 1'b1);
        blank = 1'b0;
        capture(0, -1);
        n_vec++;
        if (cap_c0 !== 16'h0000 || cap_edges !== 16) begin
            n_err++;
            $display("FAIL blank_bits: got %h edges %0d required 0000 and 16", cap_c0, cap_edges);
        end
        n_vec++;
        if (cap_latch_pulses !== 1) begin
            n_err++;
            $display("FAIL blank_latch: got %0d required 1", cap_latch_pulses);
        end
        offer(1, 16'hFFFF, 1'b1);
        blank = 1'b0;
        capture(1, -1);
        n_vec++;
        if (cap_c0 !== 16'hFFFF || cap_edges !== 16) begin
            n_err++;
            $display("FAIL invert_bits: got %h edges %0d required ffff and 16", cap_c0, cap_edges);
        end
        n_vec++;
        if (d1 !== 1'b0) begin
            n_err++;
            $display("FAIL invert_idle_data: got %b required 0", d1);
        end
    endtask

    task automatic test_chains();
        offer(2, 16'h1234, 1'b0);
        capture(2, -1);
        n_vec++;
        if (cap_c0[7:0] !== 8'h2C) begin
            n_err++;
            $display("FAIL chain0_bits: got %h required 2c", cap_c0[7:0]);
        end
        n_vec++;
        if (cap_c1[7:0] !== 8'h48) begin
            n_err++;
            $display("FAIL chain1_bits: got %h required 48", cap_c1[7:0]);
        end
        n_vec++;
        if (cap_edges !== 8 || cap_busy !== 68 || cap_latch_pulses !== 1) begin
            n_err++;
            $display("FAIL chains_len: got edges %0d busy %0d latch %0d required 8 68 1",
                     cap_edges, cap_busy, cap_latch_pulses);
        end
    endtask

    task automatic test_en_drop();
        int rdy_hi;
        int busy_hi;
        offer(0, 16'h3C96, 1'b0);
        capture(0, 10);
        n_vec++;
        if (cap_c0 !== 16'h3C96 || cap_busy !== 132) begin
            n_err++;
            $display("FAIL en_drop_frame: got %h busy %0d required 3c96 and 132", cap_c0, cap_busy);
        end
        n_vec++;
        if (cap_latch_pulses !== 1) begin
            n_err++;
            $display("FAIL en_drop_latch: got %0d required 1", cap_latch_pulses);
        end
        v0 = 1'b1;
        rdy_hi = 0;
        busy_hi = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rdy0) rdy_hi++;
            if (busy0) busy_hi++;
        end
        n_vec++;
        if (rdy_hi !== 0 || busy_hi !== 0) begin
            n_err++;
            $display("FAIL en_drop_hold: got ready %0d busy %0d cycles required 0 and 0",
                     rdy_hi, busy_hi);
        end
        v0 = 1'b0;
        en = 1'b1;
        @(negedge clk);
        n_vec++;
        if (rdy0 !== 1'b1) begin
            n_err++;
            $display("FAIL en_reassert_ready: got %b required 1", rdy0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_blank();
        test_chains();
        test_en_drop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
